// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// The fetch FSM state codes, the datapath width and the NOP encoding live here.
package if_fetch_pkg;

    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2,
        IF_ERR   = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_timer.sv
// Memory-response watchdog: loads TIMEOUT-1 on clear, counts down while enabled.
// expired is high once the count has reached zero.
module if_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch unit: PC -> instruction memory (req/ack) -> decoder (valid/ready).
// Optional build macro IF_PREFETCH_EN adds a one-entry prefetch buffer filled while in HOLD.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] RST_INSTR = NOP
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] pc_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              dec_ready,
    output logic              pc_inc,
    output logic              fetch_err
);

    if_state_e         state, state_nxt;
    logic [DATA_W-1:0] mem_addr_nxt, instr_nxt;
    logic              mem_req_nxt, instr_valid_nxt, pc_inc_nxt, fetch_err_nxt;
    logic              discard, discard_nxt;
    logic              tmr_clear, tmr_en, tmr_expired;

`ifdef IF_PREFETCH_EN
    logic [DATA_W-1:0] pf_data, pf_data_nxt;
    logic              pf_valid, pf_valid_nxt;
`endif

    if_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .n_rst   (n_rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IF_IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= RST_INSTR;
            instr_valid <= 1'b0;
            pc_inc      <= 1'b0;
            fetch_err   <= 1'b0;
            discard     <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_req     <= mem_req_nxt;
            mem_addr    <= mem_addr_nxt;
            instr       <= instr_nxt;
            instr_valid <= instr_valid_nxt;
            pc_inc      <= pc_inc_nxt;
            fetch_err   <= fetch_err_nxt;
            discard     <= discard_nxt;
        end
    end

`ifdef IF_PREFETCH_EN
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            pf_data  <= '0;
            pf_valid <= 1'b0;
        end else begin
            pf_data  <= pf_data_nxt;
            pf_valid <= pf_valid_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt       = state;
        mem_req_nxt     = mem_req;
        mem_addr_nxt    = mem_addr;
        instr_nxt       = instr;
        instr_valid_nxt = instr_valid;
        pc_inc_nxt      = 1'b0;
        fetch_err_nxt   = fetch_err;
        discard_nxt     = discard;
        tmr_clear       = 1'b0;
        tmr_en          = 1'b0;
`ifdef IF_PREFETCH_EN
        pf_data_nxt     = pf_data;
        pf_valid_nxt    = pf_valid;
`endif
        unique case (state)
            IF_IDLE: begin
                // A flush seen here holds off one cycle so the branch target is on pc_addr.
                if (!flush) begin
                    state_nxt    = IF_FETCH;
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = pc_addr;
                    tmr_clear    = 1'b1;
                end
            end
            IF_FETCH: begin
                tmr_en = 1'b1;
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    if (discard || flush) begin
                        discard_nxt = 1'b0;
                        state_nxt   = IF_IDLE;
                    end else begin
                        instr_nxt       = mem_rdata;
                        instr_valid_nxt = 1'b1;
                        pc_inc_nxt      = 1'b1;
                        state_nxt       = IF_HOLD;
                    end
                end else if (tmr_expired) begin
                    mem_req_nxt   = 1'b0;
                    fetch_err_nxt = 1'b1;
                    discard_nxt   = 1'b0;
                    state_nxt     = IF_ERR;
                end else if (flush) begin
                    // The memory still answers this request; its data must be dropped.
                    discard_nxt = 1'b1;
                end
            end
            IF_HOLD: begin
`ifdef IF_PREFETCH_EN
                tmr_en = mem_req;
                if (flush) begin
                    instr_valid_nxt = 1'b0;
                    pf_valid_nxt    = 1'b0;
                    if (mem_req && !mem_ack) begin
                        // Wait out the in-flight prefetch in FETCH and drop it there.
                        discard_nxt = 1'b1;
                        state_nxt   = IF_FETCH;
                    end else begin
                        mem_req_nxt = 1'b0;
                        state_nxt   = IF_IDLE;
                    end
                end else if (mem_req && !mem_ack && tmr_expired) begin
                    mem_req_nxt     = 1'b0;
                    fetch_err_nxt   = 1'b1;
                    instr_valid_nxt = 1'b0;
                    pf_valid_nxt    = 1'b0;
                    state_nxt       = IF_ERR;
                end else begin
                    if (mem_req && mem_ack) begin
                        mem_req_nxt  = 1'b0;
                        pc_inc_nxt   = 1'b1;
                        pf_data_nxt  = mem_rdata;
                        pf_valid_nxt = 1'b1;
                    end else if (!mem_req && !pf_valid && !pc_inc) begin
                        // pc_inc low means the PC has already moved past instr.
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = pc_addr;
                        tmr_clear    = 1'b1;
                    end
                    if (dec_ready) begin
                        if (pf_valid) begin
                            instr_nxt    = pf_data;
                            pf_valid_nxt = 1'b0;
                        end else if (mem_req && mem_ack) begin
                            instr_nxt    = mem_rdata;
                            pf_valid_nxt = 1'b0;
                        end else begin
                            instr_valid_nxt = 1'b0;
                            state_nxt       = IF_FETCH;
                            if (!mem_req) begin
                                mem_req_nxt  = 1'b1;
                                mem_addr_nxt = pc_addr;
                                tmr_clear    = 1'b1;
                            end
                        end
                    end
                end
`else
                // Flush beats a simultaneous dec_ready: the held word is wrong-path.
                if (flush) begin
                    instr_valid_nxt = 1'b0;
                    state_nxt       = IF_IDLE;
                end else if (dec_ready) begin
                    instr_valid_nxt = 1'b0;
                    mem_req_nxt     = 1'b1;
                    mem_addr_nxt    = pc_addr;
                    tmr_clear       = 1'b1;
                    state_nxt       = IF_FETCH;
                end
`endif
            end
            IF_ERR: begin
                mem_req_nxt     = 1'b0;
                instr_valid_nxt = 1'b0;
            end
            default: state_nxt = IF_IDLE;
        endcase
    end

endmodule
